// File: rtl/vol_ctrl_multi.sv
// Multi-channel volume controller: debounced UP/DOWN/MUTE buttons with auto-repeat,
// saturating per-channel attenuation, and a coalescing valid/ack volume-word output.
module vol_ctrl_multi #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CH_W     = 8,
  parameter int unsigned STEP     = 'h10,
  parameter int unsigned ATT_MAX  = 'hF0,
  parameter int unsigned ATT_DEF  = 'hF0,
  parameter int unsigned ATT_MUTE = 'hFE,
  parameter int unsigned DB_CYC   = 500000,
  parameter int unsigned RPT_DLY  = 25000000,
  parameter int unsigned RPT_PER  = 5000000
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     UP,
  input  logic                     DOWN,
  input  logic                     MUTE,
  input  logic                     VOL_RST,
  input  logic [NUM_CH-1:0]        CH_SEL,
  output logic [NUM_CH*CH_W-1:0]   VOL,
  output logic                     VOL_VALID,
  input  logic                     VOL_ACK,
  output logic                     MUTED
);

  localparam int unsigned DB_W  = $clog2(DB_CYC + 1);
  localparam int unsigned RPT_W = $clog2(RPT_DLY + 1);
  localparam int unsigned CW1   = CH_W + 1;
  localparam int unsigned VW    = NUM_CH * CH_W;

  localparam logic [CW1-1:0]    STEP_X   = CW1'(STEP);
  localparam logic [CW1-1:0]    MAX_X    = CW1'(ATT_MAX);
  localparam logic [CH_W-1:0]   MAX_L    = CH_W'(ATT_MAX);
  localparam logic [CH_W-1:0]   DEF_L    = CH_W'(ATT_DEF);
  localparam logic [CH_W-1:0]   MUTE_L   = CH_W'(ATT_MUTE);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
  localparam logic [RPT_W-1:0]  RPT_HIT  = RPT_W'(RPT_DLY);
  localparam logic [RPT_W-1:0]  RPT_RLD  = RPT_W'(RPT_DLY - RPT_PER + 1);

  typedef enum logic {S_IDLE, S_PEND} state_e;

  // Button index 0 = UP, 1 = DOWN, 2 = MUTE.
  logic [2:0]                   sync1_q, sync2_q;
  logic [2:0]                   deb_q, deb_d;
  logic [2:0][DB_W-1:0]         db_cnt_q, db_cnt_d;
  logic [2:0]                   press_q, press_d;
  logic [1:0][RPT_W-1:0]        hold_q, hold_d;
  logic                         conf_q, conf_d;
  logic [NUM_CH-1:0][CH_W-1:0]  lvl_q, lvl_d;
  logic                         muted_q, muted_d;
  logic [VW-1:0]                target_q, target_d;
  state_e                       state_q, state_d;
  logic [VW-1:0]                vol_q, vol_d;
  logic                         valid_q, valid_d;

  logic                         blk_c, ev_up_c, ev_dn_c, ev_mute_c;
  logic [1:0]                   rpt_c;
  logic [NUM_CH-1:0][CW1-1:0]   up_dif_c, dn_sum_c;

  // Debounce: accept a new level after DB_CYC consecutive differing samples.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  // Auto-repeat and UP/DOWN conflict lockout (held until both are released).
  always_comb begin
    conf_d = conf_q;
    if (deb_q[0] && deb_q[1])        conf_d = 1'b1;
    else if (!deb_q[0] && !deb_q[1]) conf_d = 1'b0;
    blk_c = conf_q | (deb_q[0] & deb_q[1]);
    for (int j = 0; j < 2; j++) begin
      rpt_c[j]  = deb_q[j] && !blk_c && (hold_q[j] == RPT_HIT);
      if (!deb_q[j] || blk_c)        hold_d[j] = '0;
      else if (hold_q[j] == RPT_HIT) hold_d[j] = RPT_RLD;
      else                           hold_d[j] = hold_q[j] + RPT_W'(1);
    end
    ev_up_c   = !blk_c && (press_q[0] || rpt_c[0]);
    ev_dn_c   = !blk_c && (press_q[1] || rpt_c[1]);
    ev_mute_c = press_q[2];
  end

  // Level arithmetic one bit wider than a channel so neither direction can wrap.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      up_dif_c[c] = {1'b0, lvl_q[c]} - STEP_X;
      dn_sum_c[c] = {1'b0, lvl_q[c]} + STEP_X;
    end
  end

  always_comb begin
    lvl_d   = lvl_q;
    muted_d = muted_q;
    if (VOL_RST) begin
      lvl_d   = {NUM_CH{DEF_L}};
      muted_d = 1'b0;
    end else begin
      if (ev_up_c) begin
        if (muted_q) begin
          muted_d = 1'b0;
        end else begin
          for (int c = 0; c < NUM_CH; c++)
            if (CH_SEL[c]) lvl_d[c] = up_dif_c[c][CH_W] ? '0 : up_dif_c[c][CH_W-1:0];
        end
      end else if (ev_dn_c && !muted_q) begin
        for (int c = 0; c < NUM_CH; c++)
          if (CH_SEL[c]) lvl_d[c] = (dn_sum_c[c] > MAX_X) ? MAX_L : dn_sum_c[c][CH_W-1:0];
      end
      if (ev_mute_c) muted_d = ~muted_d;
    end
    target_d = muted_d ? {NUM_CH{MUTE_L}} : lvl_d;
  end

  // Output handshake: VOL is frozen while PEND; target keeps absorbing updates.
  always_comb begin
    state_d = state_q;
    vol_d   = vol_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: if (target_q != vol_q) begin
        vol_d   = target_q;
        valid_d = 1'b1;
        state_d = S_PEND;
      end
      S_PEND: if (VOL_ACK) begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
      press_q  <= '0;
      hold_q   <= '0;
      conf_q   <= 1'b0;
      lvl_q    <= {NUM_CH{DEF_L}};
      muted_q  <= 1'b0;
      target_q <= {NUM_CH{DEF_L}};
      state_q  <= S_PEND;
      vol_q    <= {NUM_CH{DEF_L}};
      valid_q  <= 1'b1;
    end else begin
      sync1_q  <= {MUTE, DOWN, UP};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      hold_q   <= hold_d;
      conf_q   <= conf_d;
      lvl_q    <= lvl_d;
      muted_q  <= muted_d;
      target_q <= target_d;
      state_q  <= state_d;
      vol_q    <= vol_d;
      valid_q  <= valid_d;
    end
  end

  assign VOL       = vol_q;
  assign VOL_VALID = valid_q;
  assign MUTED     = muted_q;

endmodule

// File: tb/tb_vol_ctrl_multi.sv
// Scoreboard bench for vol_ctrl_multi: a small level/mute model pushes the expected
// volume words; every acknowledged transfer is popped and compared.
module tb_vol_ctrl_multi;

  localparam int unsigned DB  = 4;
  localparam int unsigned DLY = 16;
  localparam int unsigned PER = 4;

  logic        clk, rst_n, up, dn, mute, vol_rst, vol_ack, vol_valid, muted;
  logic [1:0]  ch_sel;
  logic [15:0] vol;

  int n_checks, n_errors, exp_xfers, got_xfers;
  logic [15:0] exp_q[$];
  logic [7:0]  m_lvl [2];
  bit          m_muted, auto_push;
  logic [15:0] last_tgt;

  vol_ctrl_multi #(.NUM_CH(2), .CH_W(8), .DB_CYC(DB), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .CLK(clk), .RST_N(rst_n), .UP(up), .DOWN(dn), .MUTE(mute), .VOL_RST(vol_rst),
    .CH_SEL(ch_sel), .VOL(vol), .VOL_VALID(vol_valid), .VOL_ACK(vol_ack), .MUTED(muted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each acknowledged transfer is one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && vol_valid && vol_ack) begin
      got_xfers++;
      if (exp_q.size() > 0) check_eq("vol_xfer", 32'(vol), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_target();
    return m_muted ? 16'hFEFE : {m_lvl[1], m_lvl[0]};
  endfunction

  task automatic push_exp(input logic [15:0] v);
    exp_q.push_back(v);
    exp_xfers++;
    last_tgt = v;
  endtask

  task automatic model_update();
    logic [15:0] t;
    t = m_target();
    if (t != last_tgt) begin
      if (auto_push) push_exp(t);
      else last_tgt = t;
    end
  endtask

  task automatic model_event(input int b);
    int s;
    for (int c = 0; c < 2; c++) begin
      if (b == 0 && !m_muted && ch_sel[c]) begin
        s = int'(m_lvl[c]) - 16;
        m_lvl[c] = (s < 0) ? 8'h00 : 8'(s);
      end else if (b == 1 && !m_muted && ch_sel[c]) begin
        s = int'(m_lvl[c]) + 16;
        m_lvl[c] = (s > 'hF0) ? 8'hF0 : 8'(s);
      end
    end
    if (b == 0) m_muted = 1'b0;
    if (b == 2) m_muted = ~m_muted;
    model_update();
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) up = v;
    else if (b == 1) dn = v;
    else mute = v;
  endtask

  // Hold a button clean for n cycles; UP/DOWN repeat at hold DLY, DLY+PER, ...
  task automatic press(input int b, input int n, input int gap);
    int evs;
    evs = 1;
    if (b != 2 && n > int'(DLY)) evs += (n - 1 - int'(DLY)) / int'(PER) + 1;
    for (int k = 0; k < evs; k++) model_event(b);
    set_btn(b, 1'b1);
    repeat (n) tick();
    set_btn(b, 1'b0);
    repeat (gap) tick();
  endtask

  task automatic model_reset();
    m_lvl[0] = 8'hF0;
    m_lvl[1] = 8'hF0;
    m_muted  = 1'b0;
  endtask

  task automatic vol_rst_pulse();
    vol_rst = 1'b1;
    tick();
    vol_rst = 1'b0;
    model_reset();
    model_update();
  endtask

  task automatic phase_end(input string tag);
    repeat (20) tick();
    check_eq(tag, 32'(got_xfers), 32'(exp_xfers));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_xfers = 0; got_xfers = 0;
    up = 0; dn = 0; mute = 0; vol_rst = 0; vol_ack = 0; ch_sel = 2'b11; rst_n = 0;
    model_reset();
    last_tgt  = 16'hF0F0;
    auto_push = 1'b1;

    // Reset state and first forced write
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vol", 32'(vol), 32'h0000F0F0);
    check_eq("rst_valid", 32'(vol_valid), 32'd1);
    check_eq("rst_muted", 32'(muted), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("valid_until_ack", 32'(vol_valid), 32'd1);
    push_exp(16'hF0F0);
    vol_ack = 1'b1;
    tick(); tick();
    check_eq("valid_after_ack", 32'(vol_valid), 32'd0);
    press(0, 10, 10);
    check_eq("one_up", 32'(vol), 32'h0000E0E0);
    phase_end("xfers_first");

    // Bounce rejection
    for (int i = 0; i < 5; i++) begin
      up = 1'b1; tick(); tick();
      up = 1'b0; tick(); tick();
    end
    repeat (10) tick();
    check_eq("bounce", 32'(vol), 32'h0000E0E0);
    phase_end("xfers_bounce");

    // UP saturation at 0, DOWN saturation at ATT_MAX
    vol_rst_pulse();
    for (int i = 0; i < 17; i++) press(0, 10, 10);
    check_eq("up_sat", 32'(vol), 32'h00000000);
    phase_end("xfers_up_sat");
    vol_rst_pulse();
    press(0, 10, 10);
    for (int i = 0; i < 3; i++) press(1, 10, 10);
    check_eq("dn_sat", 32'(vol), 32'h0000F0F0);
    phase_end("xfers_dn_sat");

    // Auto-repeat and UP+DOWN conflict
    press(0, 40, 12);
    check_eq("repeat", 32'(vol), 32'h00008080);
    phase_end("xfers_repeat");
    up = 1'b1; dn = 1'b1;
    repeat (40) tick();
    up = 1'b0; dn = 1'b0;
    repeat (12) tick();
    check_eq("conflict", 32'(vol), 32'h00008080);
    phase_end("xfers_conflict");

    // Channel mask and mute
    vol_rst_pulse();
    ch_sel = 2'b01;
    for (int i = 0; i < 3; i++) press(0, 10, 10);
    check_eq("ch_mask", 32'(vol), 32'h0000F0C0);
    press(2, 10, 10);
    check_eq("mute_vol", 32'(vol), 32'h0000FEFE);
    check_eq("mute_flag", 32'(muted), 32'd1);
    press(1, 10, 10);
    check_eq("mute_dn", 32'(vol), 32'h0000FEFE);
    press(0, 10, 10);
    check_eq("unmute_vol", 32'(vol), 32'h0000F0C0);
    check_eq("unmute_flag", 32'(muted), 32'd0);
    phase_end("xfers_mute");

    // Coalescing while the driver withholds ack
    ch_sel = 2'b11;
    vol_rst_pulse();
    phase_end("xfers_prep");
    vol_ack = 1'b0;
    auto_push = 1'b0;
    for (int i = 0; i < 3; i++) press(0, 10, 10);
    check_eq("held_vol", 32'(vol), 32'h0000E0E0);
    check_eq("held_valid", 32'(vol_valid), 32'd1);
    push_exp(16'hE0E0);
    push_exp(16'hC0C0);
    vol_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("gap_valid", 32'(vol_valid), 32'd0);
    @(negedge clk);
    check_eq("coal_valid", 32'(vol_valid), 32'd1);
    check_eq("coal_vol", 32'(vol), 32'h0000C0C0);
    @(posedge clk);
    #1;
    auto_push = 1'b1;
    phase_end("xfers_coalesce");

    // VOL_RST in the same cycle as an UP event
    up = 1'b1;
    repeat (2 + DB) tick();
    vol_rst = 1'b1;
    tick();
    vol_rst = 1'b0;
    model_reset();
    model_update();
    repeat (4) tick();
    up = 1'b0;
    repeat (12) tick();
    check_eq("rst_vs_up", 32'(vol), 32'h0000F0F0);
    phase_end("xfers_rst_vs_up");

    // Async reset mid-transfer
    vol_ack = 1'b0;
    auto_push = 1'b0;
    press(2, 10, 10);
    check_eq("pend_vol", 32'(vol), 32'h0000FEFE);
    check_eq("pend_muted", 32'(muted), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_vol", 32'(vol), 32'h0000F0F0);
    check_eq("arst_valid", 32'(vol_valid), 32'd1);
    check_eq("arst_muted", 32'(muted), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    auto_push = 1'b1;
    push_exp(16'hF0F0);
    vol_ack = 1'b1;
    phase_end("xfers_arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
